// File: rtl/wrr_pkg.sv
// Shared definitions for the 16-way weighted round-robin TX scheduler.
package wrr_pkg;
    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    localparam int WGT_W = 4;
    localparam logic [WGT_W-1:0] WGT_RST = WGT_W'(1);

    typedef enum logic [1:0] {IDLE, ARB, OFFER, SERVE} state_t;

    function automatic logic [IDX_W-1:0] oh2idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/rr_pick_16.sv
// Combinational rotating-priority picker: first eligible requester strictly after last_idx.
module rr_pick_16
    import wrr_pkg::*;
(
    input  logic [N_REQ-1:0] elig,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);
    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] masked;
    logic [2*N_REQ-1:0] first;

    // The upper copy of elig lets the search wrap, and still reaches last_idx itself last.
    always_comb begin
        dbl         = {elig, elig};
        masked      = dbl & ~(((2*N_REQ)'(2) << last_idx) - (2*N_REQ)'(1));
        first       = masked & (~masked + (2*N_REQ)'(1));
        pick_onehot = first[N_REQ-1:0] | first[2*N_REQ-1:N_REQ];
        pick_idx    = oh2idx(pick_onehot);
        pick_any    = |elig;
    end
endmodule

// File: rtl/wrr_sched_16.sv
// Weighted round-robin scheduler granting the TX packet engine to one of 16 requesters.
module wrr_sched_16
    import wrr_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cfg_wr_en,
    input  logic [IDX_W-1:0] cfg_wr_idx,
    input  logic [WGT_W-1:0] cfg_wr_weight,
    input  logic [N_REQ-1:0] sched_req,
    input  logic             eng_ready,
    input  logic             pkt_done,
    output logic             grant_valid,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             err_stray
);
    state_t           state, state_nxt;
    logic [IDX_W-1:0] last_idx, last_idx_nxt;
    logic [WGT_W-1:0] credit, credit_nxt;
    logic [WGT_W-1:0] weight [N_REQ];
    logic [N_REQ-1:0] elig, pick_onehot, onehot_nxt;
    logic [IDX_W-1:0] pick_idx, idx_nxt;
    logic             pick_any;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = sched_req[i] && (weight[i] != '0);
        end
    end

    rr_pick_16 u_pick (
        .elig        (elig),
        .last_idx    (last_idx),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_any    (pick_any)
    );

    always_comb begin
        state_nxt    = state;
        onehot_nxt   = grant_onehot;
        idx_nxt      = grant_idx;
        credit_nxt   = credit;
        last_idx_nxt = last_idx;
        case (state)
            IDLE: begin
                if (pick_any) state_nxt = ARB;
            end
            ARB: begin
                if (pick_any) begin
                    onehot_nxt = pick_onehot;
                    idx_nxt    = pick_idx;
                    state_nxt  = OFFER;
                end else begin
                    onehot_nxt = '0;
                    idx_nxt    = '0;
                    state_nxt  = IDLE;
                end
            end
            OFFER: begin
                if (eng_ready) begin
                    credit_nxt = weight[grant_idx];
                    state_nxt  = SERVE;
                end
            end
            SERVE: begin
                if (pkt_done) begin
                    credit_nxt = (credit == '0) ? '0 : credit - WGT_W'(1);
                    // A zero credit (weight cleared while offered) behaves like one packet.
                    if (credit <= WGT_W'(1) || !sched_req[grant_idx]) begin
                        last_idx_nxt = grant_idx;
                        if (pick_any) begin
                            state_nxt = ARB;
                        end else begin
                            state_nxt  = IDLE;
                            onehot_nxt = '0;
                            idx_nxt    = '0;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            last_idx     <= '1;
            credit       <= '0;
            grant_onehot <= '0;
            grant_idx    <= '0;
            grant_valid  <= 1'b0;
            busy         <= 1'b0;
            err_stray    <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                weight[i] <= WGT_RST;
            end
        end else begin
            state        <= state_nxt;
            last_idx     <= last_idx_nxt;
            credit       <= credit_nxt;
            grant_onehot <= onehot_nxt;
            grant_idx    <= idx_nxt;
            grant_valid  <= (state_nxt == OFFER);
            busy         <= (state_nxt == OFFER) || (state_nxt == SERVE);
            err_stray    <= err_stray | (pkt_done && (state != SERVE));
            if (cfg_wr_en) weight[cfg_wr_idx] <= cfg_wr_weight;
        end
    end
endmodule

// File: tb/tb_wrr_sched_16.sv
// Scoreboard bench for wrr_sched_16: expected grant indices are queued, a monitor checks each acceptance.
module tb_wrr_sched_16;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cfg_wr_en = 1'b0;
    logic [3:0]  cfg_wr_idx = '0;
    logic [3:0]  cfg_wr_weight = '0;
    logic [15:0] sched_req = '0;
    logic        eng_ready = 1'b0;
    logic        pkt_done = 1'b0;
    logic        grant_valid;
    logic [15:0] grant_onehot;
    logic [3:0]  grant_idx;
    logic        busy;
    logic        err_stray;

    int checks = 0;
    int passed = 0;
    int exp_q[$];

    wrr_sched_16 dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_wr_idx    (cfg_wr_idx),
        .cfg_wr_weight (cfg_wr_weight),
        .sched_req     (sched_req),
        .eng_ready     (eng_ready),
        .pkt_done      (pkt_done),
        .grant_valid   (grant_valid),
        .grant_onehot  (grant_onehot),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .err_stray     (err_stray)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        sys_rst   = 1'b1;
        sched_req = '0;
        pkt_done  = 1'b0;
        cfg_wr_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic wait_serve(input string name);
        int n;
        n = 0;
        while (!(busy && !grant_valid) && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            $display("FAIL %s: busy=%0d grant_valid=%0d after 40 cycles, expected busy=1 grant_valid=0",
                     name, busy, grant_valid);
        end
    endtask

    task automatic wait_gv(input string name);
        int n;
        n = 0;
        while (!grant_valid && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            $display("FAIL %s: grant_valid=0 after 40 cycles, expected 1", name);
        end
    endtask

    task automatic pulse_done();
        pkt_done = 1'b1;
        @(negedge sys_clk);
        pkt_done = 1'b0;
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [3:0] w);
        cfg_wr_idx    = idx;
        cfg_wr_weight = w;
        cfg_wr_en     = 1'b1;
        @(negedge sys_clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_gv"}, int'(grant_valid), 0);
        chk({name, "_onehot"}, int'(grant_onehot), 0);
        chk({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    // Monitor: an acceptance is grant_valid && eng_ready ahead of the next rising edge.
    initial begin
        int e;
        forever begin
            @(negedge sys_clk);
            #2;
            if (!sys_rst && grant_valid && eng_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_grant: got idx %0d, expected no grant", grant_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_idx", int'(grant_idx), e);
                    chk("grant_onehot", int'(grant_onehot), 1 << e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset values, first-grant latency, re-grant of a lone requester
        do_reset();
        chk("rst_gv", int'(grant_valid), 0);
        chk("rst_onehot", int'(grant_onehot), 0);
        chk("rst_idx", int'(grant_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err_stray), 0);
        eng_ready = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(0);
        sched_req = 16'h0001;
        @(negedge sys_clk);
        chk("t1_lat_t1", int'(grant_valid), 0);
        @(negedge sys_clk);
        chk("t1_lat_t2", int'(grant_valid), 1);
        wait_serve("t1_serve0");
        pulse_done();
        chk("t1_rel_lat_t1", int'(grant_valid), 0);
        @(negedge sys_clk);
        chk("t1_rel_lat_t2", int'(grant_valid), 1);
        wait_serve("t1_serve1");
        sched_req = '0;
        pulse_done();
        chk_idle("t1_end");

        // Test 2: plain rotation 0,2,15 twice
        do_reset();
        eng_ready = 1'b1;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(0);  exp_q.push_back(2);  exp_q.push_back(15);
        exp_q.push_back(0);  exp_q.push_back(2);  exp_q.push_back(15);
        sched_req = 16'h8005;
        for (int k = 0; k < 6; k++) begin
            wait_serve("t2_serve");
            if (k == 5) sched_req = '0;
            pulse_done();
        end
        chk_idle("t2_end");

        // Test 3: weight 3 on requester 3, weight 1 on requester 5
        do_reset();
        eng_ready = 1'b1;
        cfg_write(4'd3, 4'd3);
        cfg_write(4'd5, 4'd1);
        exp_q.push_back(3);  exp_q.push_back(5);  exp_q.push_back(3);
        sched_req = 16'h0028;
        for (int k = 0; k < 5; k++) begin
            wait_serve("t3_serve");
            if (k == 1) chk("t3_hold_3", int'(grant_idx), 3);
            if (k == 4) sched_req = '0;
            pulse_done();
        end
        chk_idle("t3_end");

        // Test 4: weight 0 disables requester 1 until rewritten
        do_reset();
        eng_ready = 1'b1;
        cfg_write(4'd1, 4'd0);
        exp_q.push_back(0);  exp_q.push_back(0);  exp_q.push_back(0);  exp_q.push_back(1);
        sched_req = 16'h0003;
        wait_serve("t4_s0");
        pulse_done();
        wait_serve("t4_s1");
        pulse_done();
        wait_serve("t4_s2");
        cfg_write(4'd1, 4'd2);
        pulse_done();
        wait_serve("t4_s3");
        chk("t4_serving_1", int'(grant_idx), 1);
        pulse_done();
        chk("t4_w2_still_serving", int'(busy && !grant_valid), 1);
        chk("t4_w2_idx", int'(grant_idx), 1);
        sched_req = '0;
        pulse_done();
        chk_idle("t4_end");

        // Test 5: grant held through a long eng_ready stall with the request withdrawn
        do_reset();
        eng_ready = 1'b0;
        exp_q.push_back(4);
        sched_req = 16'h0010;
        wait_gv("t5_offer");
        sched_req = '0;
        begin
            int stable;
            stable = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge sys_clk);
                if (grant_valid && grant_idx == 4'd4 && grant_onehot == 16'h0010) stable++;
            end
            chk("t5_hold_cycles", stable, 10);
        end
        eng_ready = 1'b1;
        wait_serve("t5_serve");
        chk("t5_serve_idx", int'(grant_idx), 4);
        pulse_done();
        chk_idle("t5_end");

        // Test 6: stray pkt_done is sticky; reset mid-SERVE clears everything
        do_reset();
        eng_ready = 1'b1;
        pulse_done();
        chk("t6_err_set", int'(err_stray), 1);
        repeat (5) @(negedge sys_clk);
        chk("t6_err_sticky", int'(err_stray), 1);
        exp_q.push_back(8);
        sched_req = 16'h0100;
        wait_serve("t6_serve8");
        chk("t6_err_kept", int'(err_stray), 1);
        sys_rst   = 1'b1;
        sched_req = '0;
        @(negedge sys_clk);
        chk("t6_rst_gv", int'(grant_valid), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_onehot", int'(grant_onehot), 0);
        chk("t6_rst_idx", int'(grant_idx), 0);
        chk("t6_rst_err", int'(err_stray), 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        exp_q.push_back(0);
        sched_req = 16'h0101;
        wait_serve("t6_serve0");
        chk("t6_first_pick", int'(grant_idx), 0);
        sched_req = '0;
        pulse_done();
        chk_idle("t6_end");
        chk("t6_no_stray_in_serve", int'(err_stray), 0);

        repeat (3) @(negedge sys_clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
